// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared types and helpers for the SPI master.
//   spi_mode_t  : SPI mode encoded as {CPOL,CPHA}
//   spi_state_t : master FSM states
//   calc_half   : clk_in cycles per SCK half period
//   mode_cpol / mode_cpha : split a mode into its clock polarity / phase
// -----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01,
      MODE2 = 2'b10,
      MODE3 = 2'b11
   } spi_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_XFER  = 3'd2,
      ST_TRAIL = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_t;

   // Odd periods round down, so the real SCK period is always 2*HALF.
   function automatic int calc_half(input int period);
      return period / 2;
   endfunction

   function automatic logic mode_cpol(input spi_mode_t mode);
      return (mode == MODE2) || (mode == MODE3);
   endfunction

   function automatic logic mode_cpha(input spi_mode_t mode);
      return (mode == MODE1) || (mode == MODE3);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
//   SCK timing for one word: a half-period counter and an SCK edge counter.
//   While en is high a strobe fires every HALF clk_in cycles; the k-th strobe
//   (k = 1..2*DATA_WIDTH) is an SCK edge, the extra strobe k = 2*DATA_WIDTH+1
//   closes the trailing half period of the word.
//   Ports:
//     clk_in, rst_n_in : clock, async active-low reset
//     en               : counting enable from the FSM; counters clear when low
//     lead_stb         : this cycle's edge is a leading SCK edge (odd k)
//     trail_stb        : this cycle's edge is a trailing SCK edge (even k)
//     last_bit         : the pending trailing edge is the final one (k = 2*DATA_WIDTH)
//     last_stb         : end of the word (k = 2*DATA_WIDTH+1)
// -----------------------------------------------------------------------------
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int HALF       = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic en,
   output logic lead_stb,
   output logic trail_stb,
   output logic last_bit,
   output logic last_stb
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int EW = $clog2(2 * DATA_WIDTH + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [EW-1:0] EDGE_END  = EW'(2 * DATA_WIDTH);

   logic [CW-1:0] half_cnt;
   logic [EW-1:0] edge_cnt;
   logic          tick;

   // edge_cnt holds the number of SCK edges already produced, so an even
   // count means the next edge is a leading one.
   assign tick      = en && (half_cnt == HALF_LAST);
   assign lead_stb  = tick && !edge_cnt[0] && (edge_cnt != EDGE_END);
   assign trail_stb = tick && edge_cnt[0];
   assign last_bit  = (edge_cnt == EDGE_END - 1'b1);
   assign last_stb  = tick && (edge_cnt == EDGE_END);

   // Half-period and edge counters; both rest at zero while not enabled
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         half_cnt <= '0;
         edge_cnt <= '0;
      end else if (!en) begin
         half_cnt <= '0;
         edge_cnt <= '0;
      end else begin
         if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
         end else begin
            half_cnt <= half_cnt + 1'b1;
         end
         if (tick) begin
            if (edge_cnt == EDGE_END) begin
               edge_cnt <= '0;
            end else begin
               edge_cnt <= edge_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_master_chk.sv
// -----------------------------------------------------------------------------
// spi_master_chk
//   Elaboration-time parameter checks for spi_master. No ports, no logic.
// -----------------------------------------------------------------------------
module spi_master_chk #(
   parameter int HALF       = 1,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CS     = 1,
   parameter int CS_GAP     = 1
) ();

   if (HALF < 1) begin : g_half_bad
      $error("spi_master: DATA_PERIOD must give a half period of at least 1");
   end
   if (DATA_WIDTH < 2) begin : g_width_bad
      $error("spi_master: DATA_WIDTH must be at least 2");
   end
   if (NUM_CS < 1) begin : g_cs_bad
      $error("spi_master: NUM_CS must be at least 1");
   end
   if (CS_GAP < 1) begin : g_gap_bad
      $error("spi_master: CS_GAP must be at least 1");
   end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Full-duplex SPI master, all four CPOL/CPHA modes, selectable bit order,
//   NUM_CS active-low chip selects and a valid/ready command handshake.
//   Ports:
//     clk_in, rst_n_in   : clock, async active-low reset
//     data_in            : word to transmit
//     cs_sel_in          : chip select index (out of range -> no select driven)
//     mode_in            : {CPOL,CPHA}, latched when a command is accepted
//     valid_in/ready_out : command handshake; ready only while idle
//     data_out           : last received word
//     data_valid_out     : one-cycle pulse when data_out updates
//     busy_out           : inverse of ready_out
//     copi_out, cipo_in  : serial data out / in
//     dclk_out           : SCK
//     sel_out            : active-low chip selects
// -----------------------------------------------------------------------------
module spi_master
   import spi_pkg::*;
#(
   parameter  int DATA_WIDTH  = 8,
   parameter  int DATA_PERIOD = 100,
   parameter  int NUM_CS      = 1,
   parameter  int CS_GAP      = 2,
   parameter  int MSB_FIRST   = 1,
   localparam int CSW         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [CSW-1:0]        cs_sel_in,
   input  logic [1:0]            mode_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid_out,
   output logic                  busy_out,
   output logic                  copi_out,
   input  logic                  cipo_in,
   output logic                  dclk_out,
   output logic [NUM_CS-1:0]     sel_out
);

   localparam int HALF = calc_half(DATA_PERIOD);
   localparam int GW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

   spi_state_t            state;
   spi_mode_t             mode;
   logic [CSW-1:0]        cs;
   logic [DATA_WIDTH-1:0] tx_sh;
   logic [DATA_WIDTH-1:0] rx_sh;
   logic [DATA_WIDTH-1:0] tx_next;
   logic [DATA_WIDTH-1:0] rx_next;
   logic [GW-1:0]         gap_cnt;
   logic                  tx_bit;
   logic                  cpol;
   logic                  cpha;
   logic                  clk_en;
   logic                  lead_stb;
   logic                  trail_stb;
   logic                  last_bit;
   logic                  last_stb;

   spi_master_chk #(
      .HALF       (HALF),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_CS     (NUM_CS),
      .CS_GAP     (CS_GAP)
   ) u_chk ();

   spi_clk_gen #(
      .HALF       (HALF),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_clk_gen (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .en        (clk_en),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb),
      .last_bit  (last_bit),
      .last_stb  (last_stb)
   );

   // An out-of-range index decodes to all selects inactive.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] idx);
      logic [NUM_CS-1:0] sel;
      sel = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (CSW'(i) == idx) begin
            sel[i] = 1'b0;
         end
      end
      return sel;
   endfunction

   assign cpol   = mode_cpol(mode);
   assign cpha   = mode_cpha(mode);
   assign clk_en = (state == ST_XFER) || (state == ST_TRAIL);

   // Bit-order dependent view of the transmit and receive shift registers
   always_comb begin
      if (MSB_FIRST != 0) begin
         tx_bit  = tx_sh[DATA_WIDTH-1];
         tx_next = {tx_sh[DATA_WIDTH-2:0], 1'b0};
         rx_next = {rx_sh[DATA_WIDTH-2:0], cipo_in};
      end else begin
         tx_bit  = tx_sh[0];
         tx_next = {1'b0, tx_sh[DATA_WIDTH-1:1]};
         rx_next = {cipo_in, rx_sh[DATA_WIDTH-1:1]};
      end
   end

   // Word sequencer: handshake, chip select, SCK, shifting and result delivery
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= ST_IDLE;
         mode           <= MODE0;
         cs             <= '0;
         tx_sh          <= '0;
         rx_sh          <= '0;
         gap_cnt        <= '0;
         ready_out      <= 1'b1;
         busy_out       <= 1'b0;
         data_out       <= '0;
         data_valid_out <= 1'b0;
         copi_out       <= 1'b0;
         dclk_out       <= 1'b0;
         sel_out        <= '1;
      end else begin
         data_valid_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid_in && ready_out) begin
                  mode      <= spi_mode_t'(mode_in);
                  cs        <= cs_sel_in;
                  tx_sh     <= data_in;
                  rx_sh     <= '0;
                  ready_out <= 1'b0;
                  busy_out  <= 1'b1;
                  state     <= ST_LEAD;
               end
            end
            ST_LEAD: begin
               sel_out  <= cs_decode(cs);
               dclk_out <= cpol;
               // CPHA=0 peripherals sample on the first edge, so the first
               // bit must already be on the line.
               if (!cpha) begin
                  copi_out <= tx_bit;
                  tx_sh    <= tx_next;
               end
               state <= ST_XFER;
            end
            ST_XFER, ST_TRAIL: begin
               if (lead_stb) begin
                  dclk_out <= ~dclk_out;
                  if (cpha) begin
                     copi_out <= tx_bit;
                     tx_sh    <= tx_next;
                  end else begin
                     rx_sh <= rx_next;
                  end
               end else if (trail_stb) begin
                  dclk_out <= ~dclk_out;
                  if (cpha) begin
                     rx_sh <= rx_next;
                  end else if (!last_bit) begin
                     copi_out <= tx_bit;
                     tx_sh    <= tx_next;
                  end
                  if (last_bit) begin
                     state <= ST_TRAIL;
                  end
               end else if (last_stb) begin
                  sel_out        <= '1;
                  copi_out       <= 1'b0;
                  dclk_out       <= cpol;
                  data_out       <= rx_sh;
                  data_valid_out <= 1'b1;
                  gap_cnt        <= '0;
                  state          <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  ready_out <= 1'b1;
                  busy_out  <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               ready_out <= 1'b1;
               busy_out  <= 1'b0;
               sel_out   <= '1;
               copi_out  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Two masters run in lockstep from the same command stream:
//     dut0: DATA_PERIOD=4, NUM_CS=2, MSB first
//     dut1: DATA_PERIOD=5, NUM_CS=3, LSB first (same half period as dut0)
//   The expected waveform of every output is computed per clock from the
//   offset since the accepting edge, using the SCK-edge arithmetic of the
//   protocol. Peripherals either loop copi back or shift out a given word.
// -----------------------------------------------------------------------------
module tb_spi_master;

   localparam int W = 8;
   localparam int H = 2;
   localparam int G = 2;
   localparam int E = 1 + (2 * W + 1) * H;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic [1:0] mode_in;
   logic [1:0] cs_sel_in;
   logic       valid_in;

   logic       ready0, busy0, dv0, copi0, dclk0, cipo0, per0;
   logic [7:0] dout0;
   logic [1:0] sel0;
   logic       ready1, busy1, dv1, copi1, dclk1, cipo1, per1;
   logic [7:0] dout1;
   logic [2:0] sel1;
   logic       loop;

   int         n_checks;
   int         n_errors;

   logic [7:0] cur_d, cur_r;
   logic [1:0] cur_m, cur_cs;
   logic [7:0] last_rx [2];
   logic       idle_cpol;

   assign cipo0 = loop ? copi0 : per0;
   assign cipo1 = loop ? copi1 : per1;

   spi_master #(.DATA_WIDTH(8), .DATA_PERIOD(4), .NUM_CS(2), .CS_GAP(2), .MSB_FIRST(1)) u_dut0 (
      .clk_in(clk), .rst_n_in(rst_n), .data_in(data_in), .cs_sel_in(cs_sel_in[0]),
      .mode_in(mode_in), .valid_in(valid_in), .ready_out(ready0), .data_out(dout0),
      .data_valid_out(dv0), .busy_out(busy0), .copi_out(copi0), .cipo_in(cipo0),
      .dclk_out(dclk0), .sel_out(sel0));

   spi_master #(.DATA_WIDTH(8), .DATA_PERIOD(5), .NUM_CS(3), .CS_GAP(2), .MSB_FIRST(0)) u_dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .data_in(data_in), .cs_sel_in(cs_sel_in),
      .mode_in(mode_in), .valid_in(valid_in), .ready_out(ready1), .data_out(dout1),
      .data_valid_out(dv1), .busy_out(busy1), .copi_out(copi1), .cipo_in(cipo1),
      .dclk_out(dclk1), .sel_out(sel1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit j in transmission order of a word.
   function automatic logic word_bit(input logic [7:0] w, input bit msb, input int j);
      return msb ? w[7 - j] : w[j];
   endfunction

   // Serial line value after clk edge n of a word: a CPHA=0 sender puts bit j
   // out after 2j SCK edges (bit 0 before the first), a CPHA=1 sender after
   // 2j+1 edges; the line is 0 outside the word.
   function automatic logic model_line(input logic [7:0] w, input bit msb, input logic [1:0] m, input int n);
      int k;
      if (n < 1 || n >= E) return 1'b0;
      k = (n - 1) / H;
      if (!m[0]) return word_bit(w, msb, (k / 2 > W - 1) ? W - 1 : k / 2);
      if (k == 0) return 1'b0;
      return word_bit(w, msb, (k - 1) / 2);
   endfunction

   function automatic logic model_dclk(input logic [1:0] m, input int n);
      int k;
      if (n < 1) return idle_cpol;
      if (n >= E) return m[1];
      k = (n - 1) / H;
      return m[1] ^ k[0];
   endfunction

   // Outputs of both DUTs n cycles after the accepting edge of the current word.
   task automatic check_cycle(input int n);
      for (int i = 0; i < 2; i++) begin
         int         ncs;
         int         csx;
         logic [2:0] exp_sel;
         logic [7:0] exp_dout;
         logic [2:0] got_sel;
         ncs      = (i == 0) ? 2 : 3;
         csx      = (i == 0) ? int'(cur_cs[0]) : int'(cur_cs);
         exp_sel  = 3'((1 << ncs) - 1);
         if (n >= 1 && n < E && csx < ncs) exp_sel[csx] = 1'b0;
         exp_dout = (n >= E) ? (loop ? cur_d : cur_r) : last_rx[i];
         got_sel  = (i == 0) ? {1'b0, sel0} : sel1;
         check_eq($sformatf("d%0d n%0d ready", i, n), 32'((i == 0) ? ready0 : ready1), 32'(n >= E + G));
         check_eq($sformatf("d%0d n%0d busy", i, n), 32'((i == 0) ? busy0 : busy1), 32'(n < E + G));
         check_eq($sformatf("d%0d n%0d sel", i, n), 32'(got_sel), 32'(exp_sel));
         check_eq($sformatf("d%0d n%0d dclk", i, n), 32'((i == 0) ? dclk0 : dclk1), 32'(model_dclk(cur_m, n)));
         check_eq($sformatf("d%0d n%0d copi", i, n), 32'((i == 0) ? copi0 : copi1),
                  32'(model_line(cur_d, i == 0, cur_m, n)));
         check_eq($sformatf("d%0d n%0d dvalid", i, n), 32'((i == 0) ? dv0 : dv1), 32'(n == E));
         check_eq($sformatf("d%0d n%0d dout", i, n), 32'((i == 0) ? dout0 : dout1), 32'(exp_dout));
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, " d0 ready"}, 32'(ready0), 32'd1);
      check_eq({tag, " d0 busy"}, 32'(busy0), 32'd0);
      check_eq({tag, " d0 sel"}, 32'(sel0), 32'h3);
      check_eq({tag, " d0 dclk"}, 32'(dclk0), 32'(idle_cpol));
      check_eq({tag, " d0 copi"}, 32'(copi0), 32'd0);
      check_eq({tag, " d0 dvalid"}, 32'(dv0), 32'd0);
      check_eq({tag, " d0 dout"}, 32'(dout0), 32'(last_rx[0]));
      check_eq({tag, " d1 ready"}, 32'(ready1), 32'd1);
      check_eq({tag, " d1 busy"}, 32'(busy1), 32'd0);
      check_eq({tag, " d1 sel"}, 32'(sel1), 32'h7);
      check_eq({tag, " d1 dclk"}, 32'(dclk1), 32'(idle_cpol));
      check_eq({tag, " d1 copi"}, 32'(copi1), 32'd0);
      check_eq({tag, " d1 dvalid"}, 32'(dv1), 32'd0);
      check_eq({tag, " d1 dout"}, 32'(dout1), 32'(last_rx[1]));
   endtask

   task automatic check_reset(input string tag);
      idle_cpol  = 1'b0;
      last_rx[0] = 8'h00;
      last_rx[1] = 8'h00;
      check_idle(tag);
   endtask

   task automatic idle(input int cycles);
      valid_in = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         check_idle("idle");
      end
   endtask

   // One word from the accepting edge to ready again. hold keeps valid_in
   // high so the next word is accepted immediately; junk toggles inputs while
   // busy; rst_at >= 0 pulls reset just before that clock edge of the word.
   task automatic run_word(input logic [7:0] d, input logic [1:0] m, input logic [1:0] cs,
                           input bit lp, input logic [7:0] r, input bit hold, input bit junk,
                           input int rst_at);
      cur_d = d; cur_m = m; cur_cs = cs; cur_r = r; loop = lp;
      data_in = d; mode_in = m; cs_sel_in = cs; valid_in = 1'b1;
      per0 = 1'b0; per1 = 1'b0;
      for (int n = 0; n <= E + G; n++) begin
         @(posedge clk); #1;
         check_cycle(n);
         per0 = model_line(r, 1'b1, m, n);
         per1 = model_line(r, 1'b0, m, n);
         if (rst_at >= 0 && n == rst_at - 1) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_reset("rst_async");
            @(posedge clk); #1;
            check_idle("rst_hold");
            rst_n = 1'b1;
            valid_in = 1'b0;
            per0 = 1'b0; per1 = 1'b0;
            return;
         end
         if (n < E + G && junk) begin
            valid_in  = 1'($urandom_range(0, 1));
            data_in   = 8'($urandom);
            mode_in   = 2'($urandom_range(0, 3));
            cs_sel_in = 2'($urandom_range(0, 3));
         end else begin
            valid_in = hold;
         end
      end
      idle_cpol  = m[1];
      last_rx[0] = lp ? d : r;
      last_rx[1] = lp ? d : r;
      per0 = 1'b0; per1 = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; valid_in = 1'b0; data_in = 8'h00; mode_in = 2'b00; cs_sel_in = 2'd0;
      per0 = 1'b0; per1 = 1'b0; loop = 1'b0;
      cur_d = 8'h00; cur_r = 8'h00; cur_m = 2'b00; cur_cs = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      rst_n = 1'b1;
      idle(2);

      // Mode 0 loopback
      run_word(8'hA5, 2'b00, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, -1);
      idle(2);
      // Modes 1..3 against a peripheral returning C3
      for (int m = 1; m < 4; m++) begin
         run_word(8'h3C, 2'(m), 2'd0, 1'b0, 8'hC3, 1'b0, 1'b0, -1);
         idle(1);
      end
      // Single set bit, peripheral returns 80
      run_word(8'h01, 2'b00, 2'd0, 1'b0, 8'h80, 1'b0, 1'b0, -1);
      idle(1);
      // Three words back to back on select 1 with valid_in held high
      run_word(8'h11, 2'b00, 2'd1, 1'b1, 8'h00, 1'b1, 1'b0, -1);
      run_word(8'h22, 2'b00, 2'd1, 1'b1, 8'h00, 1'b1, 1'b0, -1);
      run_word(8'h33, 2'b00, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0, -1);
      idle(1);
      // Reset mid-word, then a clean word
      run_word(8'hE7, 2'b00, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 15);
      idle(2);
      run_word(8'h5A, 2'b00, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, -1);
      idle(1);
      // Select index 3: out of range for dut1 (no select), select 1 on dut0
      run_word(8'hA5, 2'b00, 2'd3, 1'b1, 8'h00, 1'b0, 1'b0, -1);
      idle(1);

      // Randomized words
      for (int t = 0; t < 30; t++) begin
         bit hold;
         hold = (t != 29) && ($urandom_range(0, 3) == 0);
         run_word(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom), hold, 1'($urandom_range(0, 1)), -1);
         if (!hold) idle($urandom_range(0, 2));
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
